// File: rtl/descrypt_round_sequencer.sv
// descrypt round sequencer: drives ITERATIONS x 16 DES round steps for one
// key/salt pair, holds the captured salt for the salted expansion stage, and
// flags block init, iteration ends and pipeline-drained completion.
module descrypt_round_sequencer #(
  parameter int unsigned ITERATIONS = 25,
  parameter int unsigned PIPE_LAT   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [11:0] salt_i,
  input  logic        hold_i,
  output logic        busy_o,
  output logic        step_o,
  output logic [3:0]  round_o,
  output logic [4:0]  iter_o,
  output logic [1:0]  key_shift_o,
  output logic        load_init_o,
  output logic        iter_end_o,
  output logic [11:0] salt_out_o,
  output logic        done_o
);

  localparam int unsigned ROUND_W = 4;
  localparam int unsigned ITER_W  = 5;
  localparam int unsigned DRAIN_W = 3;
  localparam int unsigned SALT_W  = 12;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(15);
  localparam logic [ITER_W-1:0]  LAST_ITER  = ITER_W'(ITERATIONS - 1);
  // Drain counter counts down to zero, so it starts one below the latency.
  localparam logic [DRAIN_W-1:0] DRAIN_INIT =
    DRAIN_W'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [ITER_W-1:0]    iter_q,  iter_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [SALT_W-1:0]    salt_q,  salt_d;

  // State, counters and captured salt; reset abandons any hash in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      round_q <= '0;
      iter_q  <= '0;
      drain_q <= '0;
      salt_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      iter_q  <= iter_d;
      drain_q <= drain_d;
      salt_q  <= salt_d;
    end
  end

  // Next-state, counter advance and per-state strobes.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    iter_d      = iter_q;
    drain_d     = drain_q;
    salt_d      = salt_q;
    busy_o      = 1'b0;
    step_o      = 1'b0;
    key_shift_o = 2'd0;
    load_init_o = 1'b0;
    iter_end_o  = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          salt_d  = salt_i;
          round_d = '0;
          iter_d  = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy_o      = 1'b1;
        step_o      = ~hold_i;
        // Single rotate on rounds 0, 1, 8, 15 gives 28 positions per pass.
        key_shift_o = ((round_q == ROUND_W'(0)) || (round_q == ROUND_W'(1)) ||
                       (round_q == ROUND_W'(8)) || (round_q == LAST_ROUND))
                      ? 2'd1 : 2'd2;
        load_init_o = (round_q == '0) && (iter_q == '0);
        iter_end_o  = (round_q == LAST_ROUND);
        if (!hold_i) begin
          if (round_q == LAST_ROUND) begin
            round_d = '0;
            if (iter_q == LAST_ITER) begin
              iter_d  = '0;
              drain_d = DRAIN_INIT;
              state_d = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
            end else begin
              iter_d = iter_q + ITER_W'(1);
            end
          end else begin
            round_d = round_q + ROUND_W'(1);
          end
        end
      end

      S_DRAIN: begin
        busy_o = 1'b1;
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end

      S_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign round_o    = round_q;
  assign iter_o     = iter_q;
  assign salt_out_o = salt_q;

endmodule

// File: tb/tb_descrypt_round_sequencer.sv
// Self-checking bench: default instance plus two ITERATIONS=1 instances
// (PIPE_LAT 0 and 3), checked against a step-index model of one hash.
module tb_descrypt_round_sequencer;

  localparam int NSTEP = 16 * 25;
  localparam int PL    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Key-schedule rotate per round, straight from the DES schedule.
  int ks_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Default-parameter instance.
  logic        rst_i = 1'b1, start_i = 1'b0, hold_i = 1'b0;
  logic [11:0] salt_i = '0;
  logic        busy_o, step_o, load_init_o, iter_end_o, done_o;
  logic [3:0]  round_o;
  logic [4:0]  iter_o;
  logic [1:0]  key_shift_o;
  logic [11:0] salt_out_o;

  descrypt_round_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .salt_i(salt_i), .hold_i(hold_i),
    .busy_o(busy_o), .step_o(step_o), .round_o(round_o), .iter_o(iter_o),
    .key_shift_o(key_shift_o), .load_init_o(load_init_o), .iter_end_o(iter_end_o),
    .salt_out_o(salt_out_o), .done_o(done_o)
  );

  // Sweep instances share stimulus.
  logic        start_s = 1'b0;
  logic [11:0] salt_s = '0;
  logic        busy_a, step_a, li_a, ie_a, done_a;
  logic [3:0]  round_a;
  logic [4:0]  iter_a;
  logic [1:0]  ks_a;
  logic [11:0] so_a;
  logic        busy_b, step_b, li_b, ie_b, done_b;
  logic [3:0]  round_b;
  logic [4:0]  iter_b;
  logic [1:0]  ks_b;
  logic [11:0] so_b;

  descrypt_round_sequencer #(.ITERATIONS(1), .PIPE_LAT(0)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_s), .salt_i(salt_s), .hold_i(1'b0),
    .busy_o(busy_a), .step_o(step_a), .round_o(round_a), .iter_o(iter_a),
    .key_shift_o(ks_a), .load_init_o(li_a), .iter_end_o(ie_a),
    .salt_out_o(so_a), .done_o(done_a)
  );

  descrypt_round_sequencer #(.ITERATIONS(1), .PIPE_LAT(3)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_s), .salt_i(salt_s), .hold_i(1'b0),
    .busy_o(busy_b), .step_o(step_b), .round_o(round_b), .iter_o(iter_b),
    .key_shift_o(ks_b), .load_init_o(li_b), .iter_end_o(ie_b),
    .salt_out_o(so_b), .done_o(done_b)
  );

  task automatic test_reset();
    logic [15:0] obs;
    rst_i = 1'b1;
    #12;
    obs = {busy_o, step_o, round_o, iter_o, key_shift_o, load_init_o, iter_end_o, done_o};
    n_cmp++;
    if (obs !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0000", obs);
    end
    n_cmp++;
    if (salt_out_o !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_salt: got %h want 000", salt_out_o);
    end
    n_cmp++;
    if ({busy_a, step_a, done_a, busy_b, step_b, done_b} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_sweep: got %b want 000000",
               {busy_a, step_a, done_a, busy_b, step_b, done_b});
    end
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  // One full hash on the default instance. Entered and left at a negedge
  // in IDLE. h1/h2 are forced holds at given step indices, rnd_pct adds
  // random holds, poke re-asserts START mid-run and in the DONE cycle.
  task automatic run_hash(input string tag, input logic [11:0] salt,
                          input int h1_step, input int h1_len,
                          input int h2_step, input int h2_len,
                          input int rnd_pct, input bit poke, input int base_done);
    int k, cyc, d, used1, used2, nstep, nend, ks_sum, nhold, obs_done, exp_done;
    bit hold_now, exp_done_now, finished;
    logic [15:0] obs, exp_v;
    logic [2:0]  obs3, exp3;
    k = 0; cyc = 0; d = 0; used1 = 0; used2 = 0; nstep = 0; nend = 0;
    ks_sum = 0; nhold = 0; obs_done = -1; finished = 1'b0;
    hold_i = 1'b0;
    start_i = 1'b1;
    salt_i = salt;
    @(negedge clk);
    start_i = 1'b0;
    while (!finished && cyc < 2000) begin
      hold_now = 1'b0;
      if (k == h1_step && used1 < h1_len) begin
        hold_now = 1'b1; used1++;
      end else if (k == h2_step && used2 < h2_len) begin
        hold_now = 1'b1; used2++;
      end else if (rnd_pct > 0 && $urandom_range(99) < rnd_pct) begin
        hold_now = 1'b1;
      end
      exp_done_now = (k == NSTEP) && (d == PL);
      hold_i  = hold_now;
      start_i = poke && (cyc == 37 || exp_done_now);
      salt_i  = start_i ? 12'h123 : 12'($urandom);
      #1;
      if (k < NSTEP) begin
        exp_v = {1'b1, ~hold_now, 4'(k % 16), 5'(k / 16), 2'(ks_tab[k % 16]),
                 (k == 0), (k % 16 == 15), 1'b0};
        obs = {busy_o, step_o, round_o, iter_o, key_shift_o, load_init_o, iter_end_o, done_o};
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL %s_run cyc=%0d step=%0d: got %h want %h", tag, cyc, k, obs, exp_v);
        end
        if (hold_now) nhold++;
      end else begin
        exp3 = {1'b1, 1'b0, exp_done_now};
        obs3 = {busy_o, step_o, done_o};
        n_cmp++;
        if (obs3 !== exp3) begin
          n_bad++;
          $display("FAIL %s_drain cyc=%0d: got %b want %b", tag, cyc, obs3, exp3);
        end
      end
      n_cmp++;
      if (salt_out_o !== salt) begin
        n_bad++;
        $display("FAIL %s_salt cyc=%0d: got %h want %h", tag, cyc, salt_out_o, salt);
      end
      if (step_o === 1'b1) begin
        nstep++;
        if (iter_end_o === 1'b1) nend++;
        if (iter_o === 5'd0) ks_sum += int'(key_shift_o);
      end
      if (done_o === 1'b1 && obs_done < 0) obs_done = cyc;
      if (k < NSTEP) begin
        if (!hold_now) k++;
      end else if (exp_done_now) begin
        finished = 1'b1;
      end else begin
        d++;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    hold_i  = 1'b0;
    #1;
    n_cmp++;
    if (!finished) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d cycles want completion", tag, cyc);
    end
    exp_done = base_done + nhold;
    n_cmp++;
    if (obs_done != exp_done) begin
      n_bad++;
      $display("FAIL %s_done_cycle: got %0d want %0d", tag, obs_done, exp_done);
    end
    n_cmp++;
    if ({busy_o, step_o, done_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s_after_done: got %b want 000", tag, {busy_o, step_o, done_o});
    end
    n_cmp++;
    if (salt_out_o !== salt) begin
      n_bad++;
      $display("FAIL %s_salt_after: got %h want %h", tag, salt_out_o, salt);
    end
    n_cmp++;
    if (nstep != NSTEP || nend != 25) begin
      n_bad++;
      $display("FAIL %s_counts: got steps=%0d ends=%0d want 400/25", tag, nstep, nend);
    end
    n_cmp++;
    if (ks_sum != 28) begin
      n_bad++;
      $display("FAIL %s_key_shift_sum: got %0d want 28", tag, ks_sum);
    end
  endtask

  task automatic test_basic();
    run_hash("basic", 12'hABC, -1, 0, -1, 0, 0, 1'b0, NSTEP + PL);
  endtask

  task automatic test_hold();
    // ROUND=7, ITER=2 is step 39; the final step is 399.
    run_hash("hold", 12'hABC, 39, 3, NSTEP - 1, 1, 0, 1'b0, NSTEP + PL);
  endtask

  task automatic test_start_ignored();
    run_hash("poke", 12'hABC, -1, 0, -1, 0, 0, 1'b1, NSTEP + PL);
    run_hash("after_done", 12'h123, -1, 0, -1, 0, 0, 1'b0, NSTEP + PL);
  endtask

  task automatic test_random_hold();
    for (int r = 0; r < 2; r++)
      run_hash("rnd_hold", 12'($urandom), -1, 0, -1, 0, 25, 1'b0, NSTEP + PL);
  endtask

  task automatic test_async_reset();
    logic [15:0] obs;
    bit quiet;
    start_i = 1'b1;
    salt_i  = 12'h5A5;
    @(negedge clk);
    start_i = 1'b0;
    // Step 169 is ROUND=9, ITER=10.
    repeat (169) @(negedge clk);
    #1;
    n_cmp++;
    if ({round_o, iter_o} !== {4'd9, 5'd10}) begin
      n_bad++;
      $display("FAIL arst_pre: got round=%0d iter=%0d want 9/10", round_o, iter_o);
    end
    #1 rst_i = 1'b1;
    #1;
    obs = {busy_o, step_o, round_o, iter_o, key_shift_o, load_init_o, iter_end_o, done_o};
    n_cmp++;
    if (obs !== 16'h0 || salt_out_o !== 12'h0) begin
      n_bad++;
      $display("FAIL arst_outputs: got %h salt=%h want 0000 salt=000", obs, salt_out_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (busy_o !== 1'b0 || done_o !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (!quiet) begin
      n_bad++;
      $display("FAIL arst_no_resume: got activity after reset want idle");
    end
    run_hash("post_rst", 12'($urandom), -1, 0, -1, 0, 0, 1'b0, NSTEP + PL);
  endtask

  task automatic test_sweep();
    logic [11:0] s;
    logic [4:0]  obs_a, exp_a, obs_b, exp_b;
    s = 12'($urandom);
    start_s = 1'b1;
    salt_s  = s;
    @(negedge clk);
    start_s = 1'b0;
    for (int c = 0; c < 24; c++) begin
      salt_s = 12'($urandom);
      #1;
      exp_a = {(c <= 16), (c < 16), (c == 16), (c < 16) && (c % 16 == 15), (c == 0)};
      exp_b = {(c <= 19), (c < 16), (c == 19), (c < 16) && (c % 16 == 15), (c == 0)};
      obs_a = {busy_a, step_a, done_a, step_a & ie_a, step_a & li_a};
      obs_b = {busy_b, step_b, done_b, step_b & ie_b, step_b & li_b};
      n_cmp++;
      if (obs_a !== exp_a || iter_a !== 5'd0 || (c < 16 && round_a !== 4'(c))) begin
        n_bad++;
        $display("FAIL sweep_pl0 cyc=%0d: got %b r=%0d i=%0d want %b r=%0d i=0",
                 c, obs_a, round_a, iter_a, exp_a, c % 16);
      end
      n_cmp++;
      if (obs_b !== exp_b || iter_b !== 5'd0 || (c < 16 && round_b !== 4'(c))) begin
        n_bad++;
        $display("FAIL sweep_pl3 cyc=%0d: got %b r=%0d i=%0d want %b r=%0d i=0",
                 c, obs_b, round_b, iter_b, exp_b, c % 16);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (so_a !== s || so_b !== s) begin
      n_bad++;
      $display("FAIL sweep_salt: got %h/%h want %h", so_a, so_b, s);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_start_ignored();
    test_random_hold();
    test_async_reset();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/descrypt_round_sequencer.md
Name: descrypt_round_sequencer

Overview:
- Sequences one descrypt hash: ITERATIONS passes of 16 DES rounds on one key/salt pair.
- Captures the 12-bit salt at start and drives it steadily to the salted 48-bit expansion/subkey XOR stage.
- Issues one round-step strobe per clock, with round/iteration indices and key-schedule shift amount for the subkey generator.
- Signals block-init, iteration boundaries and completion to the surrounding DES round datapath and the result collector.

Parameters:
- ITERATIONS, 25: DES encryptions per hash (legal 1..31).
- PIPE_LAT, 1: register stages between a step strobe and its result (the XOR stage is one registered stage); legal 0..7.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request a new hash; sampled only in IDLE.
- SALT  in  12  salt swap mask; captured when START accepted.
- HOLD  in  1  stall; freezes step issue in RUN.
- BUSY  out  1  high in RUN, DRAIN, DONE.
- STEP  out  1  round-step strobe; the datapath advances one round when high.
- ROUND  out  4  round index of current step, 0..15.
- ITER  out  5  iteration index of current step, 0..ITERATIONS-1.
- KEY_SHIFT  out  2  key-schedule rotate for ROUND: 1 for rounds 0, 1, 8, 15; 2 otherwise.
- LOAD_INIT  out  1  high with the step ROUND=0, ITER=0; datapath selects the all-zero block instead of feedback.
- ITER_END  out  1  high with each ROUND=15 step; datapath applies end-of-encryption L/R handling.
- SALT_OUT  out  12  captured salt, to bits [59:48] of the XOR stage's Y input.
- DONE  out  1  one-cycle pulse when the final result has left the pipeline.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; SALT_OUT=0; counters 0. Reset mid-run abandons the hash; there is no resumption.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - START=1 at an edge → capture SALT into SALT_OUT; ROUND=0, ITER=0; go to RUN.
  - START=0 → remain in IDLE.
- RUN:
  - STEP = ~HOLD (combinational from state and HOLD). ROUND, ITER, KEY_SHIFT, LOAD_INIT and ITER_END are valid whenever in RUN, and are qualified by STEP.
  - On each edge with STEP=1:
    - ROUND increments; 15 wraps to 0 and increments ITER.
    - At ROUND=15 with ITER=ITERATIONS-1 → go to DRAIN (or DONE if PIPE_LAT=0); the drain counter loads PIPE_LAT-1.
  - HOLD=1: counters and outputs frozen; no step is lost or duplicated.
- DRAIN:
  - STEP=0. HOLD ignored.
  - Counter decrements each cycle; at 0 go to DONE. DRAIN lasts exactly PIPE_LAT cycles.
- DONE:
  - DONE=1 for exactly one cycle, then IDLE. START in this cycle is ignored.
- Timing: with no HOLD, the first STEP occurs the cycle after the START edge. There are 16*ITERATIONS consecutive STEP cycles, then PIPE_LAT drain cycles. DONE is high in cycle 16*ITERATIONS+PIPE_LAT after the first STEP cycle; that is cycle 401 for the defaults, with cycles numbered from 0.
- SALT_OUT holds from capture until the next accepted START or reset; it is unchanged by DONE. SALT changes during a run have no effect.
- START while BUSY is ignored (no queueing).
- ITER never exceeds ITERATIONS-1; ROUND never exceeds 15.
- LOAD_INIT is never high outside the first step. ITER_END is high on exactly ITERATIONS steps per hash.
- BUSY falls in the cycle after DONE.

Test Plan:
- Reset, START=1, SALT=12'hABC, HOLD=0, defaults → SALT_OUT=12'hABC. 400 contiguous STEP cycles. ROUND sequence 0..15 repeating; ITER 0..24. LOAD_INIT exactly on step 0. ITER_END on steps 15, 31, …, 399. DONE single pulse at cycle 401. BUSY low the next cycle.
- KEY_SHIFT check over one iteration → pattern 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; the sum per iteration is 28.
- HOLD=1 for 3 cycles at ROUND=7, ITER=2, and again for 1 cycle at the final step → no STEP during holds, indices frozen, total STEP count still 400. DONE delayed by exactly 4 cycles (cycle 405).
- START re-asserted during RUN with SALT=12'h123, and again in the DONE cycle → both ignored. SALT_OUT stays 12'hABC. A START one cycle after DONE is accepted and SALT_OUT=12'h123.
- RST asserted asynchronously mid-RUN (ROUND=9, ITER=10) → all outputs 0 immediately, no DONE. After release, a new START produces a clean 400-step run.
- Parameter sweep ITERATIONS=1 with PIPE_LAT=0, and ITERATIONS=1 with PIPE_LAT=3 → 16 steps; DONE at cycle 16 and cycle 19 respectively; ITER stays 0 throughout.
